// File: rtl/pwm_array.sv
// -----------------------------------------------------------------------------
// pwm_array
//
// Multi-channel PWM generator for the transducer driver. Every channel owns a
// free-running time counter that wraps at its own period CYCLE[i], plus an
// active rise/fall edge pair that sets where its registered PWM output is
// high within each period.
//
// Duty/phase settings arrive serially, one channel per clock, while DIN_VALID
// is high. A two-stage pipeline turns each (cycle, duty, phase) beat into
// rise/fall edge times and writes them to that channel's shadow registers.
// After the last channel of a frame is written, DOUT_VALID pulses for one
// cycle and every channel is marked pending. A pending channel copies its
// shadow values to its active registers on its own last count (TIME_CNT ==
// CYCLE-1), so the new settings govern whole periods only.
//
// Ports:
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   DIN_VALID   high while DUTY/PHASE stream channels 0..TRANS_NUM-1
//   CYCLE       per-channel period in clocks (2..2^WIDTH-1)
//   DUTY        high time (clocks) of the channel being streamed
//   PHASE       phase offset of the channel being streamed (0..CYCLE-1)
//   PWM_OUT     registered PWM output per channel
//   TIME_CNT    per-channel time counter
//   DOUT_VALID  one-cycle pulse once a complete frame is in the shadow regs
// -----------------------------------------------------------------------------
module pwm_array #(
  parameter int unsigned WIDTH     = 13,
  parameter int unsigned TRANS_NUM = 249
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                DIN_VALID,
  input  logic [TRANS_NUM-1:0][WIDTH-1:0]     CYCLE,
  input  logic [WIDTH-1:0]                    DUTY,
  input  logic [WIDTH-1:0]                    PHASE,
  output logic [TRANS_NUM-1:0]                PWM_OUT,
  output logic [TRANS_NUM-1:0][WIDTH-1:0]     TIME_CNT,
  output logic                                DOUT_VALID
);

  localparam int unsigned IdxW = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  // Edge arithmetic needs headroom for 2*c before the modulo reduction.
  localparam int unsigned ExtW = WIDTH + 2;

  // ---------------------------------------------------------------------------
  // Load index: which channel the current DUTY/PHASE beat belongs to.
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] idx_q, idx_d;
  logic            beat_last;
  logic [WIDTH-1:0] beat_cycle;

  assign beat_last  = (idx_q == IdxW'(TRANS_NUM - 1));
  assign beat_cycle = CYCLE[idx_q];

  // Dropping DIN_VALID abandons a partial frame; the index also returns to 0
  // after the last channel so back-to-back frames line up.
  always_comb begin
    idx_d = '0;
    if (DIN_VALID && !beat_last) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the beat together with the period it refers to.
  // ---------------------------------------------------------------------------
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [IdxW-1:0]  s1_idx_q;
  logic [WIDTH-1:0] s1_cycle_q;
  logic [WIDTH-1:0] s1_duty_q;
  logic [WIDTH-1:0] s1_phase_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_cycle_q <= '0;
      s1_duty_q  <= '0;
      s1_phase_q <= '0;
    end else begin
      s1_valid_q <= DIN_VALID;
      s1_last_q  <= DIN_VALID && beat_last;
      s1_idx_q   <= idx_q;
      s1_cycle_q <= beat_cycle;
      s1_duty_q  <= DUTY;
      s1_phase_q <= PHASE;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 (combinational, registered into the shadow regs):
  //   rise = (2c - p - floor(d/2))   mod c
  //   fall = (c  - p + floor((d+1)/2)) mod c
  // With p < c and d < c both raw values lie in [0, 2c], so two conditional
  // subtractions of c complete the modulo. With d >= c the channel is forced
  // fully on and the edge values are never used.
  // ---------------------------------------------------------------------------
  logic [ExtW-1:0]  c_x, p_x, dh_lo, dh_hi;
  logic [ExtW-1:0]  rise_raw, rise_m1, rise_m2;
  logic [ExtW-1:0]  fall_raw, fall_m1, fall_m2;
  logic [WIDTH-1:0] calc_rise, calc_fall;
  logic             calc_full;
  logic             unused_edge_hi;

  always_comb begin
    c_x      = {2'b00, s1_cycle_q};
    p_x      = {2'b00, s1_phase_q};
    dh_lo    = {3'b000, s1_duty_q[WIDTH-1:1]};
    dh_hi    = ({2'b00, s1_duty_q} + ExtW'(1)) >> 1;

    rise_raw = (c_x << 1) - p_x - dh_lo;
    rise_m1  = (rise_raw >= c_x) ? rise_raw - c_x : rise_raw;
    rise_m2  = (rise_m1 >= c_x) ? rise_m1 - c_x : rise_m1;

    fall_raw = c_x - p_x + dh_hi;
    fall_m1  = (fall_raw >= c_x) ? fall_raw - c_x : fall_raw;
    fall_m2  = (fall_m1 >= c_x) ? fall_m1 - c_x : fall_m1;

    calc_rise = rise_m2[WIDTH-1:0];
    calc_fall = fall_m2[WIDTH-1:0];
    calc_full = (s1_duty_q >= s1_cycle_q);
  end

  // After reduction the top bits are always zero.
  assign unused_edge_hi = ^{rise_m2[ExtW-1:WIDTH], fall_m2[ExtW-1:WIDTH]};

  // ---------------------------------------------------------------------------
  // Frame-complete pulse: the last channel's shadow write lands on the same
  // edge that raises DOUT_VALID.
  // ---------------------------------------------------------------------------
  logic dout_valid_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= s1_valid_q && s1_last_q;
    end
  end

  assign DOUT_VALID = dout_valid_q;

  // ---------------------------------------------------------------------------
  // Per-channel state: time counter, shadow/active edges, pending, output.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < TRANS_NUM; i++) begin : g_ch
    logic [WIDTH-1:0] time_cnt_q, time_cnt_d;
    logic [WIDTH-1:0] last_cnt;
    logic             at_wrap;
    logic             activate;

    logic [WIDTH-1:0] sh_rise_q, sh_fall_q;
    logic             sh_full_q;
    logic [WIDTH-1:0] act_rise_q, act_fall_q;
    logic             act_full_q;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;

    assign last_cnt = CYCLE[i] - WIDTH'(1);
    // ">=" rather than "==" so a shrinking period recovers on the next clock.
    assign at_wrap  = (time_cnt_q >= last_cnt);
    assign activate = pending_q && (time_cnt_q == last_cnt);

    always_comb begin
      time_cnt_d = at_wrap ? '0 : time_cnt_q + WIDTH'(1);
    end

    // A fresh frame re-arms pending even if an older one never activated,
    // so the most recent frame is the one that takes effect.
    always_comb begin
      pending_d = pending_q;
      if (dout_valid_q) begin
        pending_d = 1'b1;
      end else if (activate) begin
        pending_d = 1'b0;
      end
    end

    // Output for the next cycle from the current count. The high window is
    // [rise, fall) and may wrap around the period boundary.
    always_comb begin
      pwm_d = 1'b0;
      if (act_full_q) begin
        pwm_d = 1'b1;
      end else if (act_rise_q <= act_fall_q) begin
        pwm_d = (act_rise_q <= time_cnt_q) && (time_cnt_q < act_fall_q);
      end else begin
        pwm_d = (time_cnt_q >= act_rise_q) || (time_cnt_q < act_fall_q);
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        time_cnt_q <= '0;
        sh_rise_q  <= '0;
        sh_fall_q  <= '0;
        sh_full_q  <= 1'b0;
        act_rise_q <= '0;
        act_fall_q <= '0;
        act_full_q <= 1'b0;
        pending_q  <= 1'b0;
        pwm_q      <= 1'b0;
      end else begin
        time_cnt_q <= time_cnt_d;
        pending_q  <= pending_d;
        pwm_q      <= pwm_d;
        if (s1_valid_q && (s1_idx_q == IdxW'(i))) begin
          sh_rise_q <= calc_rise;
          sh_fall_q <= calc_fall;
          sh_full_q <= calc_full;
        end
        // Reads the registered shadow values, so a shadow write on this
        // same edge never leaks into the active set.
        if (activate) begin
          act_rise_q <= sh_rise_q;
          act_fall_q <= sh_fall_q;
          act_full_q <= sh_full_q;
        end
      end
    end

    assign TIME_CNT[i] = time_cnt_q;
    assign PWM_OUT[i]  = pwm_q;
  end

endmodule

// File: tb/tb_pwm_array.sv
module tb_pwm_array;

  localparam int W = 13;
  localparam int N = 4;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                DIN_VALID = 1'b0;
  logic [N-1:0][W-1:0] CYCLE;
  logic [W-1:0]        DUTY = '0;
  logic [W-1:0]        PHASE = '0;
  logic [N-1:0]        PWM_OUT;
  logic [N-1:0][W-1:0] TIME_CNT;
  logic                DOUT_VALID;

  pwm_array #(
    .WIDTH    (W),
    .TRANS_NUM(N)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIN_VALID (DIN_VALID),
    .CYCLE     (CYCLE),
    .DUTY      (DUTY),
    .PHASE     (PHASE),
    .PWM_OUT   (PWM_OUT),
    .TIME_CNT  (TIME_CNT),
    .DOUT_VALID(DOUT_VALID)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  int fr_d[N];
  int fr_p[N];

  typedef struct {
    int c;
    int d;
    int p;
    int r;
    int f;
    bit full;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference edges straight from the rule, using integer modulo.
  function automatic int ref_r(input int c, input int p, input int d);
    return (2 * c - p - d / 2) % c;
  endfunction

  function automatic int ref_f(input int c, input int p, input int d);
    return (c - p + (d + 1) / 2) % c;
  endfunction

  // High iff t lies in the circular window [r, f) of a period of length c.
  function automatic int exp_pwm(input int c, input int r, input int f, input bit full,
                                 input int t);
    if (full) return 1;
    return (((t - r + c) % c) < ((f - r + c) % c)) ? 1 : 0;
  endfunction

  task automatic send_frame(input int beats);
    for (int b = 0; b < beats; b++) begin
      @(negedge CLK);
      DIN_VALID = 1'b1;
      DUTY      = W'(fr_d[b]);
      PHASE     = W'(fr_p[b]);
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    DUTY      = '0;
    PHASE     = '0;
    check("dout_early", DOUT_VALID, 0);
    @(negedge CLK);
    check("dout_pulse", DOUT_VALID, (beats == N) ? 1 : 0);
    @(negedge CLK);
    check("dout_after", DOUT_VALID, 0);
  endtask

  // Waits for the channel's last count, then checks one full period of output.
  task automatic check_period(input int ch, input int c, input int r, input int f,
                              input bit full);
    int guard = 0;
    int prev;
    while ((int'(TIME_CNT[ch]) != c - 1) && (guard < 2 * c + 16)) begin
      @(negedge CLK);
      guard++;
    end
    if (int'(TIME_CNT[ch]) != c - 1) begin
      check("period_sync_timeout", TIME_CNT[ch], c - 1);
      return;
    end
    @(negedge CLK);
    check("period_start", TIME_CNT[ch], 0);
    for (int k = 0; k < c; k++) begin
      prev = int'(TIME_CNT[ch]);
      @(negedge CLK);
      check("pwm", PWM_OUT[ch], exp_pwm(c, r, f, full, prev));
      check("tc_step", TIME_CNT[ch], (prev + 1) % c);
    end
  endtask

  task automatic set_all(input int c, input int d, input int p);
    for (int ch = 0; ch < N; ch++) begin
      CYCLE[ch] = W'(c);
      fr_d[ch]  = d;
      fr_p[ch]  = p;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    int rc[N];

    vecs[0] = '{c: 4096, d: 2048, p: 0,    r: 3072, f: 1024, full: 1'b0};
    vecs[1] = '{c: 2000, d: 500,  p: 100,  r: 1650, f: 150,  full: 1'b0};
    vecs[2] = '{c: 2000, d: 100,  p: 1900, r: 50,   f: 150,  full: 1'b0};
    vecs[3] = '{c: 2000, d: 0,    p: 7,    r: 1993, f: 1993, full: 1'b0};
    vecs[4] = '{c: 300,  d: 300,  p: 5,    r: 0,    f: 0,    full: 1'b1};
    vecs[5] = '{c: 300,  d: 299,  p: 0,    r: 151,  f: 150,  full: 1'b0};
    vecs[6] = '{c: 500,  d: 100,  p: 499,  r: 451,  f: 51,   full: 1'b0};

    set_all(4096, 0, 0);

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_pwm", PWM_OUT, 0);
    check("rst_tc", TIME_CNT, 0);
    check("rst_dout", DOUT_VALID, 0);
    RST_N = 1'b1;
    check("rel_tc0", TIME_CNT[0], 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      for (int ch = 0; ch < N; ch++) check("rel_count", TIME_CNT[ch], k);
    end

    // Wrap at 4096, then shrink the period below the current count.
    guard = 0;
    while (int'(TIME_CNT[0]) != 4095 && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    check("wrap_reach", TIME_CNT[0], 4095);
    @(negedge CLK);
    check("wrap_zero", TIME_CNT[0], 0);
    guard = 0;
    while (int'(TIME_CNT[0]) != 3000 && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    check("shrink_reach", TIME_CNT[0], 3000);
    CYCLE[0] = W'(2000);
    @(negedge CLK);
    check("shrink_zero", TIME_CNT[0], 0);
    check("shrink_other", TIME_CNT[1], 3001);
    @(negedge CLK);
    check("shrink_next", TIME_CNT[0], 1);

    // Directed edge vectors.
    foreach (vecs[v]) begin
      @(negedge CLK);
      set_all(vecs[v].c, vecs[v].d, vecs[v].p);
      send_frame(N);
      check_period(0, vecs[v].c, vecs[v].r, vecs[v].f, vecs[v].full);
    end

    // Aborted frame: no pulse, and the last vector stays in force.
    set_all(500, 250, 0);
    send_frame(2);
    repeat (4) begin
      @(negedge CLK);
      check("abort_no_dout", DOUT_VALID, 0);
    end
    check_period(0, vecs[6].c, vecs[6].r, vecs[6].f, vecs[6].full);

    // Randomized frames against the reference formula, all channels.
    for (int fr = 0; fr < 12; fr++) begin
      @(negedge CLK);
      for (int ch = 0; ch < N; ch++) begin
        rc[ch]    = int'($urandom_range(150, 16));
        fr_d[ch]  = int'($urandom_range(rc[ch] / 2, 0));
        fr_p[ch]  = int'($urandom_range(rc[ch] - 1, 0));
        CYCLE[ch] = W'(rc[ch]);
      end
      send_frame(N);
      for (int ch = 0; ch < N; ch++) begin
        check_period(ch, rc[ch], ref_r(rc[ch], fr_p[ch], fr_d[ch]),
                     ref_f(rc[ch], fr_p[ch], fr_d[ch]), 1'b0);
      end
    end

    // Full-on everywhere, then an asynchronous reset mid-period.
    @(negedge CLK);
    set_all(64, 64, 3);
    send_frame(N);
    for (int ch = 0; ch < N; ch++) check_period(ch, 64, 0, 0, 1'b1);
    check("pre_rst_pwm", PWM_OUT, 4'hF);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_pwm", PWM_OUT, 0);
    check("async_rst_tc", TIME_CNT, 0);
    check("async_rst_dout", DOUT_VALID, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      check("rst2_count", TIME_CNT[2], k);
      check("rst2_pwm", PWM_OUT, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
